// File: rtl/n_ms_c2_accumulator.sv
// Sign-magnitude operand accumulator: converts each operand to W-bit two's complement,
// sums COUNT operands per batch and hands the result on over a 4-phase handshake.
module n_ms_c2_accumulator #(
  parameter int N     = 2,
  parameter int W     = 4,
  parameter int COUNT = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [N-1:0] x_abs,
  input  logic         sgn,
  input  logic         dav_,
  output logic         rfd,
  output logic [W-1:0] sum,
  output logic         ow,
  output logic         dav_out_,
  input  logic         rfd_out
);

  localparam int CW = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    S_READY   = 2'd0,
    S_RELEASE = 2'd1,
    S_OUT     = 2'd2,
    S_OUT_REL = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           acc_ow_q, acc_ow_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           ow_q, ow_d;
  logic           rfd_q, rfd_d;
  logic           dav_out_q, dav_out_d;

  logic [W-1:0]   x_ext;
  logic [W-1:0]   v;
  logic [W-1:0]   acc_next;
  logic           add_ovf;

  // Negative zero falls out naturally: -0 == 0 in W bits.
  always_comb begin
    x_ext    = W'(x_abs);
    v        = sgn ? (-x_ext) : x_ext;
    acc_next = acc_q + v;
    add_ovf  = (acc_q[W-1] == v[W-1]) && (acc_next[W-1] != acc_q[W-1]);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_ow_d  = acc_ow_q;
    sum_d     = sum_q;
    ow_d      = ow_q;
    rfd_d     = rfd_q;
    dav_out_d = dav_out_q;

    case (state_q)
      S_READY: begin
        if (!dav_) begin
          acc_d    = acc_next;
          acc_ow_d = acc_ow_q | add_ovf;
          cnt_d    = cnt_q + CW'(1);
          rfd_d    = 1'b0;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (dav_) begin
          if (cnt_q == CW'(COUNT)) begin
            sum_d     = acc_q;
            ow_d      = acc_ow_q;
            dav_out_d = 1'b0;
            state_d   = S_OUT;
          end else begin
            rfd_d   = 1'b1;
            state_d = S_READY;
          end
        end
      end
      S_OUT: begin
        // Wait for the consumer's low phase even if rfd_out is already high.
        if (!rfd_out) begin
          dav_out_d = 1'b1;
          state_d   = S_OUT_REL;
        end
      end
      S_OUT_REL: begin
        if (rfd_out) begin
          acc_d    = '0;
          acc_ow_d = 1'b0;
          cnt_d    = '0;
          rfd_d    = 1'b1;
          state_d  = S_READY;
        end
      end
      default: begin
        state_d   = S_READY;
        acc_d     = '0;
        cnt_d     = '0;
        acc_ow_d  = 1'b0;
        sum_d     = '0;
        ow_d      = 1'b0;
        rfd_d     = 1'b1;
        dav_out_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q   <= S_READY;
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_ow_q  <= 1'b0;
      sum_q     <= '0;
      ow_q      <= 1'b0;
      rfd_q     <= 1'b1;
      dav_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      acc_ow_q  <= acc_ow_d;
      sum_q     <= sum_d;
      ow_q      <= ow_d;
      rfd_q     <= rfd_d;
      dav_out_q <= dav_out_d;
    end
  end

  assign rfd      = rfd_q;
  assign sum      = sum_q;
  assign ow       = ow_q;
  assign dav_out_ = dav_out_q;

endmodule

// File: tb/tb_n_ms_c2_accumulator.sv
// Self-checking bench for n_ms_c2_accumulator: directed and random batches
// checked against an integer-arithmetic reference model.
module tb_n_ms_c2_accumulator;
  localparam int N = 2;
  localparam int W = 4;
  localparam int COUNT = 4;

  logic         clock = 1'b0;
  logic         reset_;
  logic [N-1:0] x_abs;
  logic         sgn;
  logic         dav_;
  logic         rfd_out;
  wire          rfd;
  wire  [W-1:0] sum;
  wire          ow;
  wire          dav_out_;

  int tests = 0;
  int fails = 0;

  // reference model state: signed accumulator as a plain integer
  int model_acc = 0;
  bit model_ow  = 1'b0;

  always #5 clock = ~clock;

  n_ms_c2_accumulator #(.N(N), .W(W), .COUNT(COUNT)) dut (
    .clock   (clock),
    .reset_  (reset_),
    .x_abs   (x_abs),
    .sgn     (sgn),
    .dav_    (dav_),
    .rfd     (rfd),
    .sum     (sum),
    .ow      (ow),
    .dav_out_(dav_out_),
    .rfd_out (rfd_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_reset();
    model_acc = 0;
    model_ow  = 1'b0;
  endfunction

  function automatic void model_add(input int x, input bit s);
    int v;
    int n;
    v = s ? -x : x;
    n = model_acc + v;
    if (n > 7 || n < -8) model_ow = 1'b1;
    if (n > 7)  n -= 16;
    if (n < -8) n += 16;
    model_acc = n;
  endfunction

  function automatic logic [W-1:0] model_sum();
    logic [W-1:0] r;
    r = W'(model_acc);
    return r;
  endfunction

  // Present one operand; hold dav_ low for 'hold' cycles, checking rfd stays low.
  task automatic send_op(input string tag, input int x, input bit s, input int hold);
    int k;
    k = 0;
    while (rfd !== 1'b1 && k < 50) begin tick(); k++; end
    tests++;
    if (rfd !== 1'b1) begin
      fails++;
      $display("FAIL %s rfd_wait: rfd=%b required 1", tag, rfd);
    end
    x_abs = N'(x);
    sgn   = s;
    dav_  = 1'b0;
    tick();
    tests++;
    if (rfd !== 1'b0) begin
      fails++;
      $display("FAIL %s rfd_latency: rfd=%b required 0", tag, rfd);
    end
    for (int i = 1; i < hold; i++) begin
      x_abs = N'($urandom);
      sgn   = 1'($urandom);
      tick();
      tests++;
      if (rfd !== 1'b0) begin
        fails++;
        $display("FAIL %s rfd_hold cycle %0d: rfd=%b required 0", tag, i, rfd);
      end
    end
    dav_  = 1'b1;
    x_abs = N'($urandom);
    sgn   = 1'($urandom);
    model_add(x, s);
    tick();
  endtask

  // Receive a batch result, delaying the consumer's low phase by 'delay' cycles.
  task automatic recv_result(input string tag, input int delay);
    int k;
    logic [W-1:0] exp_sum;
    exp_sum = model_sum();
    k = 0;
    while (dav_out_ !== 1'b0 && k < 50) begin tick(); k++; end
    tests++;
    if (dav_out_ !== 1'b0) begin
      fails++;
      $display("FAIL %s dav_out_wait: dav_out_=%b required 0", tag, dav_out_);
    end
    tests++;
    if (sum !== exp_sum || ow !== model_ow) begin
      fails++;
      $display("FAIL %s result: sum=%b ow=%b required sum=%b ow=%b", tag, sum, ow, exp_sum, model_ow);
    end
    $display("[TB] %s: sum=%b ow=%b expected sum=%b ow=%b", tag, sum, ow, exp_sum, model_ow);
    for (int i = 0; i < delay; i++) begin
      tick();
      tests++;
      if (dav_out_ !== 1'b0 || sum !== exp_sum || rfd !== 1'b0) begin
        fails++;
        $display("FAIL %s out_hold cycle %0d: dav_out_=%b sum=%b rfd=%b required 0 %b 0",
                 tag, i, dav_out_, sum, rfd, exp_sum);
      end
    end
    rfd_out = 1'b0;
    tick();
    tests++;
    if (dav_out_ !== 1'b1 || rfd !== 1'b0) begin
      fails++;
      $display("FAIL %s out_release: dav_out_=%b rfd=%b required 1 0", tag, dav_out_, rfd);
    end
    for (int i = 0; i < delay / 2; i++) begin
      tick();
      tests++;
      if (rfd !== 1'b0 || sum !== exp_sum) begin
        fails++;
        $display("FAIL %s rel_hold cycle %0d: rfd=%b sum=%b required 0 %b", tag, i, rfd, sum, exp_sum);
      end
    end
    rfd_out = 1'b1;
    tick();
    tests++;
    if (rfd !== 1'b1) begin
      fails++;
      $display("FAIL %s rfd_restart: rfd=%b required 1", tag, rfd);
    end
    model_reset();
  endtask

  task automatic run_batch(input string tag, input int xs[4], input bit ss[4], input int delay);
    for (int i = 0; i < COUNT; i++) send_op(tag, xs[i], ss[i], 1);
    recv_result(tag, delay);
  endtask

  task automatic test_reset();
    int xs[4];
    bit ss[4];
    reset_ = 1'b0;
    #3;
    reset_ = 1'b1;
    tick();
    tests++;
    if (rfd !== 1'b1 || dav_out_ !== 1'b1 || sum !== '0 || ow !== 1'b0) begin
      fails++;
      $display("FAIL reset_init: rfd=%b dav_out_=%b sum=%b ow=%b required 1 1 0000 0", rfd, dav_out_, sum, ow);
    end
    // leave a nonzero result in place, then abort a partial batch
    xs = '{3, 3, 1, 2}; ss = '{0, 0, 0, 1};
    run_batch("reset_pre", xs, ss, 0);
    send_op("reset_partial", 1, 0, 1);
    send_op("reset_partial", 1, 0, 1);
    #2;
    reset_ = 1'b0;
    #1;
    tests++;
    if (rfd !== 1'b1 || dav_out_ !== 1'b1 || sum !== '0 || ow !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: rfd=%b dav_out_=%b sum=%b ow=%b required 1 1 0000 0", rfd, dav_out_, sum, ow);
    end
    model_reset();
    tick();
    reset_ = 1'b1;
    tick();
    xs = '{1, 1, 1, 1}; ss = '{0, 0, 0, 0};
    run_batch("reset_post", xs, ss, 0);
  endtask

  task automatic test_mixed();
    int xs[4];
    bit ss[4];
    xs = '{3, 3, 1, 2}; ss = '{0, 0, 0, 1};
    run_batch("mixed", xs, ss, 1);
  endtask

  task automatic test_neg_edge();
    int xs[4];
    bit ss[4];
    xs = '{3, 3, 2, 1}; ss = '{1, 1, 1, 0};
    run_batch("neg_edge", xs, ss, 1);
  endtask

  task automatic test_overflow();
    int xs[4];
    bit ss[4];
    xs = '{3, 3, 3, 3}; ss = '{0, 0, 0, 1};
    run_batch("overflow", xs, ss, 1);
  endtask

  task automatic test_neg_zero();
    int xs[4];
    bit ss[4];
    xs = '{0, 0, 0, 0}; ss = '{1, 1, 1, 1};
    run_batch("neg_zero", xs, ss, 1);
  endtask

  task automatic test_handshake_hold();
    send_op("hold", 2, 0, 5);
    send_op("hold", 1, 1, 1);
    send_op("hold", 3, 0, 3);
    send_op("hold", 1, 0, 1);
    recv_result("hold", 10);
    // next batch must start from a cleared accumulator
    send_op("after_hold", 1, 1, 1);
    send_op("after_hold", 0, 0, 1);
    send_op("after_hold", 2, 1, 1);
    send_op("after_hold", 1, 0, 1);
    recv_result("after_hold", 2);
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < COUNT; i++)
        send_op($sformatf("random%0d", b), int'($urandom_range(0, 3)), 1'($urandom),
                int'($urandom_range(1, 3)));
      recv_result($sformatf("random%0d", b), int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    reset_  = 1'b1;
    x_abs   = '0;
    sgn     = 1'b0;
    dav_    = 1'b1;
    rfd_out = 1'b1;
    #2;
    test_reset();
    test_mixed();
    test_neg_edge();
    test_overflow();
    test_neg_zero();
    test_handshake_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
